// File: rtl/sec_awe_pkg.sv
// Shared definitions for the SEC (61,52) encoder/decoder pair.
//   DATA_W / CHK_W / CODE_W : code geometry
//   sec_state_e             : iterative engine state (idle, run, done)
//   h_col(i)                : 7-bit parity-check column for data bit i, H_i = 2*i + 3
// The decoder imports the same package so both sides agree on the columns.
package sec_awe_pkg;

  localparam int unsigned DATA_W = 52;
  localparam int unsigned CHK_W  = 9;
  localparam int unsigned CODE_W = DATA_W + CHK_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sec_state_e;

  // Odd, weight >= 2 and unique for i = 0..51 (values 3..105).
  function automatic logic [6:0] h_col(input logic [5:0] i);
    return {i, 1'b0} + 7'd3;
  endfunction

endpackage

// File: rtl/sec_awe_chk_acc.sv
// Combinational fold of a LANES-wide data slice into an 8-bit partial check.
//   data_i [LANES-1:0] : data bits base_i .. base_i+LANES-1
//   base_i [5:0]       : index of data_i[0] within the 52-bit word
//   part_o [7:0]       : {parity of slice, XOR of H columns of set bits}
module sec_awe_chk_acc
  import sec_awe_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic [LANES-1:0] data_i,
  input  logic [5:0]       base_i,
  output logic [7:0]       part_o
);

  always_comb begin
    part_o = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (data_i[j]) begin
        // Each set bit toggles the parity bit and adds its column to the syndrome.
        part_o = part_o ^ {1'b1, h_col(base_i + 6'(j))};
      end
    end
  end

endmodule

// File: rtl/sec_encoder_awe_52bits_clk.sv
// Clocked, iterative SEC encoder: 52-bit data N -> 61-bit codeword W = {chk[8:0], N}.
// Check bits accumulate LANES data bits per cycle (LANES must divide 52:
// 1, 2, 4, 13, 26 or 52), so a word takes 52/LANES cycles after start.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, honoured only when idle or done
//   N          : data word, captured on the accepted start
//   busy       : high while folding
//   done       : high while W holds a finished codeword
//   W          : {chk[8:0], data[51:0]}
// Optional build macro SEC_ENC_ERR_INJECT_EN adds inj_en / inj_pos (sampled with
// start) that invert one codeword bit (positions >= 61 ignored) for decoder tests.
module sec_encoder_awe_52bits_clk
  import sec_awe_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] N,
`ifdef SEC_ENC_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [5:0]        inj_pos,
`endif
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] W
);

  sec_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CODE_W-1:0] w_q, w_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LANES-1:0]  slice;
  logic [7:0]        part;
  logic [7:0]        acc_new;
  logic [6:0]        cnt_sum;
  logic              last_fold;
  logic [CHK_W-1:0]  chk_full;
  logic [CODE_W-1:0] flip_mask;

`ifdef SEC_ENC_ERR_INJECT_EN
  logic       inj_en_q, inj_en_d;
  logic [5:0] inj_pos_q, inj_pos_d;

  assign flip_mask = (inj_en_q && (inj_pos_q < 6'd61)) ? (CODE_W'(1) << inj_pos_q) : '0;
`else
  assign flip_mask = '0;
`endif

  assign slice     = LANES'(data_q >> cnt_q);
  assign acc_new   = acc_q ^ part;
  assign cnt_sum   = {1'b0, cnt_q} + 7'(LANES);
  assign last_fold = (cnt_sum == 7'(DATA_W));
  // Top bit makes the whole codeword even weight.
  assign chk_full  = {^acc_new, acc_new};

  sec_awe_chk_acc #(
    .LANES (LANES)
  ) u_chk_acc (
    .data_i (slice),
    .base_i (cnt_q),
    .part_o (part)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SEC_ENC_ERR_INJECT_EN
    inj_en_d  = inj_en_q;
    inj_pos_d = inj_pos_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          data_d  = N;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef SEC_ENC_ERR_INJECT_EN
          inj_en_d  = inj_en;
          inj_pos_d = inj_pos;
`endif
        end
      end
      StRun: begin
        acc_d = acc_new;
        if (last_fold) begin
          // Counter parks at 0 so it never holds a value >= 52.
          state_d = StDone;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          w_d     = {chk_full, data_q} ^ flip_mask;
        end else begin
          cnt_d = cnt_sum[5:0];
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEC_ENC_ERR_INJECT_EN
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEC_ENC_ERR_INJECT_EN
      inj_en_q  <= inj_en_d;
      inj_pos_q <= inj_pos_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign W    = w_q;

endmodule

// File: doc/sec_encoder_awe_52bits_clk.md
Name: sec_encoder_awe_52bits_clk

Overview:
Clocked, iterative SEC encoder. It is the transmit-side counterpart of the clocked SEC decoder: it takes a 52-bit data word N and produces the 61-bit codeword W that the decoder consumes. Check bits accumulate LANES data bits per cycle. The start/busy/done handshake mirrors the decoder's found-style completion flag, so the two blocks can be chained back-to-back in loopback benches.

Parameters:
DATA_W, 52, data bits per word (fixed by the code; not for override)
CHK_W, 9, check bits (fixed)
CODE_W, 61, codeword width = DATA_W + CHK_W
LANES, 1, data bits folded per cycle; legal values 1, 2, 4, 13, 26, 52 (must divide DATA_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
N  in  52  data word, captured on the accepted start cycle
busy  out  1  high while in RUN
done  out  1  high in DONE; W valid
W  out  61  codeword {chk[8:0], data[51:0]}

Behaviour:
- Code definition: column H_i = 2*i+3 (7-bit, odd, weight ≥2, unique) for i = 0..51.
  - chk[6:0] = XOR of H_i over all i with N[i]=1.
  - chk[7] = XOR of N[51:0].
  - chk[8] = XOR of chk[7:0], so the full codeword has even weight.
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, W=0, counter=0, accumulator=0, data register=0.
- FSM IDLE: start=1 -> capture N into data register, clear accumulator, counter=0, go to RUN.
- FSM RUN: each cycle, fold data bits [counter .. counter+LANES-1] into the accumulator; counter += LANES. The fold that processes the last lane (counter+LANES = 52) goes to DONE. start is ignored in RUN.
- FSM DONE: W = {chk, data} registered on DONE entry; done=1. W and done hold until start=1, which captures new N and goes to RUN. done drops in the same cycle busy rises.
- Latency: start accepted at edge k -> done=1 after edge k + 52/LANES. Examples: 52 cycles for LANES=1, 1 cycle for LANES=52.
- N changes after capture have no effect on the current word.
- Counter is 6 bits; no wrap is possible; values ≥52 are unreachable.
- Reset asserted in RUN or DONE aborts immediately to the reset values; no partial W is ever presented with done=1.
- busy and done are never high together.

Optional Feature:
SEC_ENC_ERR_INJECT_EN
- Defined: adds ports inj_en (in, 1) and inj_pos (in, 6), both sampled with start.
  - If inj_en=1 and inj_pos<61, bit inj_pos of W is inverted when W is registered on DONE entry.
  - inj_pos ≥61 is ignored.
  - Used to generate single-error vectors for the decoder.
- Undefined: ports absent; W is always the clean codeword.

Decomposition:
- Package sec_awe_pkg holds:
  - constants DATA_W, CHK_W, CODE_W
  - function h_col(i) returning the 7-bit column
  - the state enum {IDLE, RUN, DONE}
  - The decoder reuses the same package for the same constants and H columns.
- One sub-module, sec_awe_chk_acc: combinational LANES-wide fold of the data slice into the 8-bit partial check {parity, syndrome}. The top level holds the FSM, counter and registers.

Test Plan:
- Reset mid-RUN (LANES=1, assert rst_n=0 at cycle 20) -> busy=0, done=0, W=0 immediately. A following start with N=1 completes normally.
- N=0, LANES=1 -> done rises exactly 52 cycles after start; W=0.
- N=1 -> W=0x1830000000000001 (chk=387). Required for LANES=1, 4 and 52, with latencies 52, 13 and 1 cycle respectively.
- N=4503599627370495 (all ones) -> W=1625799465480749055 (chk=0x168). Loop into the clocked decoder -> decoder reports found with N=4503599627370495.
- start held high through RUN, and N changed in RUN -> no restart; W matches the value captured at start. A back-to-back start in DONE is accepted the same cycle: done=0, busy=1 next cycle.
- With SEC_ENC_ERR_INJECT_EN, N=1, inj_en=1, inj_pos=0 -> W=0x1830000000000000. With inj_pos=63 -> W=0x1830000000000001.
